// File: rtl/croc_sram_bank_arbiter_pkg.sv
// Shared constants and helpers for the SRAM bank arbiter slice.
package croc_sram_bank_arbiter_pkg;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  localparam int unsigned BankArbNumMgr   = 4;
  localparam int unsigned BankArbIdxWidth = idx_width(BankArbNumMgr);

endpackage

// File: rtl/croc_sram_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on update.
module croc_rr_arbiter
  import croc_sram_bank_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = BankArbNumMgr,
  parameter int unsigned IdxWidth = idx_width(NumReq)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumReq-1:0]   req_i,
  input  logic                update_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o
);

  logic [IdxWidth-1:0] rr_ptr_q;
  logic                found;
  int unsigned         cand;

  // Search upward from rr_ptr with wrap-around; first requester wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && req_i[IdxWidth'(cand)]) begin
        found                   = 1'b1;
        idx_o                   = IdxWidth'(cand);
        gnt_o[IdxWidth'(cand)]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (update_i) begin
      rr_ptr_q <= (32'(idx_o) == NumReq - 1) ? '0 : idx_o + IdxWidth'(1);
    end
  end

endmodule

// File: rtl/croc_sram_bank_arbiter.sv
// Round-robin sharing of one 1-cycle-latency SRAM bank among NumMgr OBI managers.
// Optional address range check: define CROC_SRAM_ARB_RANGE_CHECK_EN.
module croc_sram_bank_arbiter
  import croc_sram_bank_arbiter_pkg::*;
#(
  parameter int unsigned          NumMgr       = BankArbNumMgr,
  parameter int unsigned          NumWords     = 128,
  parameter int unsigned          AddrWidth    = 32,
  parameter int unsigned          DataWidth    = 32,
  parameter int unsigned          IdWidth      = 3,
  parameter logic [AddrWidth-1:0] BankBaseAddr = 32'h1000_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumMgr-1:0]             mgr_req_i,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0]     mgr_aid_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic [IdWidth-1:0]            mgr_rid_o,
  output logic                          mgr_err_o,
  output logic                          sram_req_o,
  output logic                          sram_we_o,
  output logic [$clog2(NumWords)-1:0]   sram_addr_o,
  output logic [DataWidth/8-1:0]        sram_be_o,
  output logic [DataWidth-1:0]          sram_wdata_o,
  input  logic [DataWidth-1:0]          sram_rdata_i
);

  localparam int unsigned BeWidth   = DataWidth / 8;
  localparam int unsigned WordWidth = $clog2(NumWords);
  localparam int unsigned IdxWidth  = idx_width(NumMgr);

  logic [NumMgr-1:0]    gnt;
  logic [IdxWidth-1:0]  win_idx;
  logic                 accept;
  logic [AddrWidth-1:0] win_addr;
  logic                 win_we;
  logic [BeWidth-1:0]   win_be;
  logic [DataWidth-1:0] win_wdata;
  logic [IdWidth-1:0]   win_aid;
  logic                 range_err;
  logic                 sram_en;

  logic                 resp_valid_q;
  logic [NumMgr-1:0]    resp_mgr_q;
  logic [IdWidth-1:0]   resp_id_q;
  logic                 resp_err_q;
  logic                 resp_we_q;

  croc_rr_arbiter #(
    .NumReq   (NumMgr),
    .IdxWidth (IdxWidth)
  ) i_rr_arbiter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (mgr_req_i),
    .update_i (accept),
    .gnt_o    (gnt),
    .idx_o    (win_idx)
  );

  assign accept    = |gnt;
  assign mgr_gnt_o = gnt;

  assign win_addr  = mgr_addr_i[win_idx*AddrWidth +: AddrWidth];
  assign win_we    = mgr_we_i[win_idx];
  assign win_be    = mgr_be_i[win_idx*BeWidth +: BeWidth];
  assign win_wdata = mgr_wdata_i[win_idx*DataWidth +: DataWidth];
  assign win_aid   = mgr_aid_i[win_idx*IdWidth +: IdWidth];

`ifdef CROC_SRAM_ARB_RANGE_CHECK_EN
  // One extra bit so the bank end address cannot wrap at the top of the address space.
  localparam logic [AddrWidth:0] BankEnd =
    {1'b0, BankBaseAddr} + (AddrWidth+1)'(NumWords * 4);

  assign range_err = (win_addr < BankBaseAddr) ||
                     ({1'b0, win_addr} >= BankEnd) ||
                     (win_addr[1:0] != 2'b00);
`else
  logic addr_unused;

  assign range_err   = 1'b0;
  assign addr_unused = ^{win_addr[AddrWidth-1:WordWidth+2], win_addr[1:0]};
`endif

  // Out-of-range requests are granted but never reach the macro.
  assign sram_en      = accept & ~range_err;
  assign sram_req_o   = sram_en;
  assign sram_we_o    = sram_en & win_we;
  assign sram_addr_o  = sram_en ? win_addr[2 +: WordWidth] : '0;
  assign sram_be_o    = sram_en ? win_be : '0;
  assign sram_wdata_o = sram_en ? win_wdata : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_mgr_q   <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      resp_valid_q <= accept;
      resp_mgr_q   <= gnt;
      if (accept) begin
        resp_id_q  <= win_aid;
        resp_err_q <= range_err;
        resp_we_q  <= win_we;
      end
    end
  end

  assign mgr_rvalid_o = resp_mgr_q;
  assign mgr_rid_o    = resp_id_q;
  assign mgr_err_o    = resp_valid_q & resp_err_q;
  assign mgr_rdata_o  = (resp_valid_q & ~resp_we_q & ~resp_err_q) ? sram_rdata_i : '0;

endmodule

// File: doc/croc_sram_bank_arbiter.md
Name: croc_sram_bank_arbiter

Overview:
Shares one single-port SRAM bank (1-cycle read latency) between NumMgr OBI managers using round-robin arbitration. It grants at most one request per cycle, drives the macro port, and returns rvalid/rdata/rid to the granted manager one cycle later. It sits between the crossbar's bank outputs and the SRAM macro wrapper, so a bank can accept several managers directly without a crossbar stage.

Parameters:
NumMgr, 4, number of competing OBI managers (2..8).
NumWords, 128, words per bank; matches the SRAM bank depth constant.
AddrWidth, 32, OBI address width.
DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.
IdWidth, 3, OBI aid/rid width; matches the subordinate-side config.
BankBaseAddr, 32'h1000_0000, byte base address of this bank.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
mgr_req_i  in  NumMgr  per-manager request
mgr_addr_i  in  NumMgr*AddrWidth  byte addresses
mgr_we_i  in  NumMgr  write enable
mgr_be_i  in  NumMgr*DataWidth/8  byte enables
mgr_wdata_i  in  NumMgr*DataWidth  write data
mgr_aid_i  in  NumMgr*IdWidth  transaction IDs
mgr_gnt_o  out  NumMgr  grant, one-hot or zero
mgr_rvalid_o  out  NumMgr  response valid, one-hot or zero
mgr_rdata_o  out  DataWidth  response data, shared by all managers
mgr_rid_o  out  IdWidth  response ID, shared by all managers
mgr_err_o  out  1  response error, shared by all managers
sram_req_o  out  1  macro access strobe
sram_we_o  out  1  macro write
sram_addr_o  out  $clog2(NumWords)  word index
sram_be_o  out  DataWidth/8  macro byte enables
sram_wdata_o  out  DataWidth  macro write data
sram_rdata_i  in  DataWidth  macro read data, valid the cycle after sram_req_o

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Arbitration is combinational. The winner is the first asserted mgr_req_i at or after rr_ptr, searching upward with wrap-around.
- mgr_gnt_o[winner] is asserted in the same cycle. No other grant bit is asserted.
- Handshake: a request is accepted when req & gnt are both high. After acceptance, the manager may change all of its inputs.
- Any request not granted stays pending. It keeps req high and may not change its payload (OBI rule); the block does not check this.
- rr_ptr update: on each accepted request, rr_ptr <= winner+1, wrapping from NumMgr-1 to 0. When no request is accepted, rr_ptr holds.
- Starvation bound: a manager that holds req high is granted within NumMgr cycles.
- SRAM drive: on acceptance, sram_req_o=1. sram_we_o, sram_be_o and sram_wdata_o pass through from the winner. sram_addr_o = winner addr[2 +: $clog2(NumWords)].
- When nothing is accepted, all sram_* outputs are 0.
- Response stage registers: resp_valid_q, resp_mgr_q (one-hot), resp_id_q, resp_err_q. All are loaded on acceptance.
- In the cycle after acceptance:
  - mgr_rvalid_o = resp_mgr_q.
  - mgr_rid_o = resp_id_q.
  - mgr_rdata_o = sram_rdata_i on reads; 0 on writes and on errors.
- Throughput and latency: one accepted request per cycle (back-to-back). Grant-to-rvalid latency is exactly 1 cycle. rvalid stays asserted for 1 cycle only; there is no rready (UseRReady=0).
- Reset values:
  - rr_ptr=0, resp_valid_q=0, resp_mgr_q=0, resp_id_q=0, resp_err_q=0.
  - Combinational outputs are 0 whenever no mgr_req_i is asserted.
- Reset asserted mid-transaction: any pending rvalid is dropped and never delivered. The first cycle after reset release has arbitration starting at manager 0.
- Simultaneous requests from all managers: grants rotate 0,1,2,3,0,...
- A single manager requesting continuously is granted every cycle.
- Address bits outside the word index are ignored unless the optional feature below is enabled.

Optional Feature:
Macro CROC_SRAM_ARB_RANGE_CHECK_EN.
- Defined:
  - A request is out of range when addr < BankBaseAddr or addr >= BankBaseAddr + NumWords*4. It also is out of range when addr[1:0] != 0.
  - An out-of-range request is still granted, but sram_req_o stays 0.
  - Next cycle: rvalid with mgr_err_o=1, rdata=0, rid echoed.
  - A write to an out-of-range address does not modify memory.
- Undefined: no check; mgr_err_o is constant 0.

Decomposition:
- Shared package: add bank-arbiter constants there.
  - Manager count for the bank arbiter, default 4.
  - Derived bank index width, computed with the same cf_math idx_width helper.
- Sub-module: croc_rr_arbiter (NumReq). Inputs: req vector, update strobe. Outputs: one-hot gnt, winner index. Internally holds rr_ptr, updated on the strobe.
  - The top level adds the SRAM mux, the response registers and the range check.

Test Plan:
- Reset, then mgr0 writes addr 0x1000_0010, wdata 0xDEADBEEF, be 4'hF, aid 1:
  - same cycle: sram_addr=4, sram_we=1;
  - next cycle: rvalid[0]=1, rid=1, err=0.
- mgr2 reads 0x1000_0010 with aid 5 -> next cycle: rvalid[2]=1, rdata=0xDEADBEEF, rid=5.
- All 4 managers request reads continuously for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3 with one rvalid per cycle, each lagging its grant by 1.
- Byte write be=4'b0010 wdata 0x0000_AB00 to word 4, then read -> 0xDEADABEF.
- Grant in cycle N, reset pulsed in cycle N+1 -> no rvalid after release, and the next grant goes to the lowest requesting index.
- With CROC_SRAM_ARB_RANGE_CHECK_EN:
  - read 0x1000_0200 -> gnt=1, sram_req=0, next cycle err=1, rdata=0;
  - read 0x1000_0002 -> err=1.
